// File: rtl/max_tracker_32bit.sv
// Packet max/min/count tracker fed by signed 32-bit comparators.
// Define TRACKER_MIN_EN to compile in the minimum path; otherwise min_val reads zero.

module comparator_32bit (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_gt,
  output logic        o_eq
);
  assign o_gt = $signed(i_a) > $signed(i_b);
  assign o_eq = (i_a == i_b);
endmodule

module max_tracker_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] max_val,
  output logic [31:0] min_val,
  output logic [15:0] max_count,
  output logic [15:0] sample_count
);
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t      r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_first;
  logic [31:0] r_max_val;
  logic [15:0] r_max_count;
  logic [15:0] r_sample_count;

  logic        w_accept;
  logic        w_max_gt;
  logic        w_max_eq;
  logic [15:0] w_max_count_inc;
  logic [15:0] w_sample_count_inc;

  assign w_accept = in_valid && r_in_ready;

  comparator_32bit u_cmp_max (
    .i_a  (in_data),
    .i_b  (r_max_val),
    .o_gt (w_max_gt),
    .o_eq (w_max_eq)
  );

  // Counters stick at all-ones rather than wrapping.
  assign w_max_count_inc    = (r_max_count == 16'hFFFF) ? r_max_count : r_max_count + 16'd1;
  assign w_sample_count_inc = (r_sample_count == 16'hFFFF) ? r_sample_count : r_sample_count + 16'd1;

`ifdef TRACKER_MIN_EN
  logic [31:0] r_min_val;
  logic        w_min_gt;
  logic        w_min_eq_unused;

  comparator_32bit u_cmp_min (
    .i_a  (r_min_val),
    .i_b  (in_data),
    .o_gt (w_min_gt),
    .o_eq (w_min_eq_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min_val <= 32'h0;
    end else if (r_state == S_ACCUM && w_accept && (r_first || w_min_gt)) begin
      r_min_val <= in_data;
    end
  end

  assign min_val = r_min_val;
`else
  assign min_val = 32'h0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_in_ready     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_first        <= 1'b0;
      r_max_val      <= 32'h0;
      r_max_count    <= 16'h0;
      r_sample_count <= 16'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state        <= S_ACCUM;
            r_in_ready     <= 1'b1;
            r_first        <= 1'b1;
            r_max_count    <= 16'h0;
            r_sample_count <= 16'h0;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            if (r_first) begin
              r_first        <= 1'b0;
              r_max_val      <= in_data;
              r_max_count    <= 16'd1;
              r_sample_count <= 16'd1;
            end else begin
              if (w_max_gt) begin
                r_max_val   <= in_data;
                r_max_count <= 16'd1;
              end else if (w_max_eq) begin
                r_max_count <= w_max_count_inc;
              end
              r_sample_count <= w_sample_count_inc;
            end
            if (in_last) begin
              r_state     <= S_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign max_val      = r_max_val;
  assign max_count    = r_max_count;
  assign sample_count = r_sample_count;
endmodule
